// File: rtl/arm_regfile.sv
//============================================================================
// Module      : arm_regfile
// Description : ARM architectural register file. R0-R14 live in flops and
//               R15 reads return the externally supplied PC+8. Three
//               combinational read ports and one synchronous write port.
//               Optional macro REGFILE_BYPASS_EN adds write-to-read bypass.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module arm_regfile #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we3,
    input  logic [3:0]        ra1,
    input  logic [3:0]        ra2,
    input  logic [3:0]        ra3,
    input  logic [3:0]        wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic [DATA_W-1:0] r15,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd3
);

    localparam int         c_NUM_REGS = 15;
    localparam logic [3:0] c_PC_ADDR  = 4'hF;

    logic [DATA_W-1:0] regs_q [c_NUM_REGS];
    logic [DATA_W-1:0] regs_d [c_NUM_REGS];
    logic [3:0]        w_ra   [3];
    logic              w_wr_en;

    // A write to address 15 is dropped here; the PC logic owns R15.
    assign w_wr_en = we3 && (wa3 != c_PC_ADDR);

    always_comb begin
        for (int i = 0; i < c_NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (w_wr_en && (wa3 == 4'(i))) begin
                regs_d[i] = wd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_NUM_REGS; i++) begin
            if (reset) begin
                regs_q[i] <= RESET_VAL;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign w_ra[0] = ra1;
    assign w_ra[1] = ra2;
    assign w_ra[2] = ra3;

    generate
        for (genvar p = 0; p < 3; p++) begin : g_rd
            logic [DATA_W-1:0] w_rd;
            always_comb begin
                w_rd = r15;
                for (int i = 0; i < c_NUM_REGS; i++) begin
                    if (w_ra[p] == 4'(i)) begin
                        w_rd = regs_q[i];
                    end
                end
`ifdef REGFILE_BYPASS_EN
                // Forward in-flight write data; address 15 is excluded via w_wr_en.
                if (w_wr_en && !reset && (w_ra[p] == wa3)) begin
                    w_rd = wd3;
                end
`endif
            end
        end
    endgenerate

    assign rd1 = g_rd[0].w_rd;
    assign rd2 = g_rd[1].w_rd;
    assign rd3 = g_rd[2].w_rd;

endmodule

`default_nettype wire

// File: tb/tb_arm_regfile.sv
//============================================================================
// Module      : tb_arm_regfile
// Description : Self-checking bench for arm_regfile: directed vector table
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_arm_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, we3;
    logic [3:0]  ra1, ra2, ra3, wa3;
    logic [31:0] wd3, r15, rd1, rd2, rd3;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  a1, a2, a3;
        logic [31:0] pc;
        logic        chk;
        logic [31:0] e1, e2, e3;
    } vec_t;

    vec_t        vecs [15];
    logic [31:0] model [15];

    arm_regfile #(.DATA_W(32), .RESET_VAL(32'h0)) dut (
        .clk(clk), .reset(reset), .we3(we3),
        .ra1(ra1), .ra2(ra2), .ra3(ra3), .wa3(wa3),
        .wd3(wd3), .r15(r15),
        .rd1(rd1), .rd2(rd2), .rd3(rd3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference read: PC for address 15, stored value otherwise, with the
    // pending write visible only when forwarding is built in.
    function automatic logic [31:0] ref_read(input logic [3:0] a, input logic rst,
                                             input logic we, input logic [3:0] wa,
                                             input logic [31:0] wd, input logic [31:0] pc);
        if (a == 4'd15) return pc;
        if (BYP && we && !rst && wa != 4'd15 && a == wa) return wd;
        return model[a];
    endfunction

    task automatic drive(input vec_t v);
        reset = v.rst; we3 = v.we; wa3 = v.wa; wd3 = v.wd;
        ra1 = v.a1; ra2 = v.a2; ra3 = v.a3; r15 = v.pc;
    endtask

    initial begin
        logic [31:0] s1, s2;
        vec_t        rv;

        vecs[0]  = '{1'b1, 1'b1, 4'd0, 32'h1234_5678, 4'd0, 4'd0, 4'd0, 32'h8, 1'b0, 32'h0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd7, 4'd14, 32'h8, 1'b1, 32'h0, 32'h0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 4'd1, 32'd10, 4'd15, 4'd3, 4'd2, 32'h8, 1'b1, 32'h8, 32'h0, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 4'd2, 32'd15, 4'd1, 4'd0, 4'd15, 32'h8, 1'b1, 32'd10, 32'h0, 32'h8};
        vecs[4]  = '{1'b0, 1'b0, 4'd0, 32'h0, 4'd1, 4'd2, 4'd0, 32'h8, 1'b1, 32'd10, 32'd15, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 4'd15, 32'hDEAD_BEEF, 4'd15, 4'd15, 4'd1, 32'h40, 1'b1, 32'h40, 32'h40, 32'd10};
        vecs[6]  = '{1'b0, 1'b0, 4'd0, 32'h0, 4'd15, 4'd2, 4'd1, 32'h40, 1'b1, 32'h40, 32'd15, 32'd10};
        vecs[7]  = '{1'b0, 1'b1, 4'd3, 32'd5, 4'd2, 4'd1, 4'd0, 32'h0, 1'b1, 32'd15, 32'd10, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 4'd3, 32'd99, 4'd3, 4'd3, 4'd3, 32'h0, 1'b1, 32'd5, 32'd5, 32'd5};
        vecs[9]  = '{1'b0, 1'b1, 4'd4, 32'd1, 4'd3, 4'd2, 4'd1, 32'h0, 1'b1, 32'd5, 32'd15, 32'd10};
        vecs[10] = '{1'b0, 1'b1, 4'd4, 32'd77, 4'd4, 4'd4, 4'd4, 32'h0, 1'b1,
                     BYP ? 32'd77 : 32'd1, BYP ? 32'd77 : 32'd1, BYP ? 32'd77 : 32'd1};
        vecs[11] = '{1'b0, 1'b1, 4'd5, 32'd33, 4'd4, 4'd4, 4'd4, 32'h0, 1'b1, 32'd77, 32'd77, 32'd77};
        vecs[12] = '{1'b0, 1'b0, 4'd0, 32'h0, 4'd5, 4'd0, 4'd15, 32'h100, 1'b1, 32'd33, 32'h0, 32'h100};
        vecs[13] = '{1'b1, 1'b1, 4'd5, 32'd44, 4'd5, 4'd5, 4'd5, 32'h0, 1'b1, 32'd33, 32'd33, 32'd33};
        vecs[14] = '{1'b0, 1'b0, 4'd0, 32'h0, 4'd5, 4'd1, 4'd4, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0};

        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i]);
            #2;
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
                check($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
                check($sformatf("vec%0d_rd3", i), rd3, vecs[i].e3);
            end
            if (i == 4) begin
                s1 = rd1; s2 = rd2;
                check("alu_add", s1 + s2, 32'd25);
                check("alu_sub", s1 - s2, 32'hFFFF_FFFB);
                check("alu_and", s1 & s2, 32'd10);
                check("alu_orr", s1 | s2, 32'd15);
            end
            @(negedge clk);
        end

        // Register file is all-zero after the reset in vector 13.
        for (int i = 0; i < 15; i++) model[i] = 32'h0;

        for (int n = 0; n < 400; n++) begin
            rv.rst = ($urandom_range(0, 31) == 0);
            rv.we  = $urandom_range(0, 1);
            rv.wa  = 4'($urandom_range(0, 15));
            rv.wd  = $urandom;
            rv.a1  = 4'($urandom_range(0, 15));
            rv.a2  = ($urandom_range(0, 3) == 0) ? rv.wa : 4'($urandom_range(0, 15));
            rv.a3  = ($urandom_range(0, 3) == 0) ? rv.wa : 4'($urandom_range(0, 15));
            rv.pc  = $urandom;
            drive(rv);
            #2;
            check("rand_rd1", rd1, ref_read(rv.a1, rv.rst, rv.we, rv.wa, rv.wd, rv.pc));
            check("rand_rd2", rd2, ref_read(rv.a2, rv.rst, rv.we, rv.wa, rv.wd, rv.pc));
            check("rand_rd3", rd3, ref_read(rv.a3, rv.rst, rv.we, rv.wa, rv.wd, rv.pc));
            // r15 must pass through in the same cycle.
            r15 = ~rv.pc;
            #1;
            if (rv.a1 == 4'd15) check("rand_r15_live", rd1, ~rv.pc);
            r15 = rv.pc;
            @(posedge clk);
            if (rv.rst) begin
                for (int i = 0; i < 15; i++) model[i] = 32'h0;
            end else if (rv.we && rv.wa != 4'd15) begin
                model[rv.wa] = rv.wd;
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
